instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of the control unit (CU): holds a 32-entry instruction store, a program counter and a dwell counter, and presents each 20-bit instruction on `instr` for exactly as many cycles as the CU's multi-cycle FSM consumes it. Classes are encoded in `instr[19:18]`: 01 std_op, 10 loadR, 11 storeR, 00 halt. The store is written through a load port while idle. Execution runs from address 0 after `start`.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/instr_store.sv | 27 ++
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction geometry, class codes and per-class dwell lengths.
// Imported by the fetch stage and the control unit.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 20;
  localparam int unsigned ADDR_BITS   = 5;
  localparam int unsigned STD_CYCLES  = 3;
  localparam int unsigned MEM_CYCLES  = 4;

  typedef enum logic [1:0] {
    CLS_HALT  = 2'b00,
    CLS_STD   = 2'b01,
    CLS_LOAD  = 2'b10,
    CLS_STORE = 2'b11
  } instr_cls_e;

endpackage

// File: rtl/instr_store.sv
// Instruction store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a program survives rst.
module instr_store
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = INSTR_WIDTH,
  parameter int unsigned AW    = ADDR_BITS
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage feeding the control unit: presents each stored instruction on instr
// for exactly as many cycles as the CU's multi-cycle FSM spends on it.
module instr_fetch #(
  parameter int unsigned INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter int unsigned ADDR_BITS   = cpu_pkg::ADDR_BITS,
  parameter int unsigned STD_CYCLES  = cpu_pkg::STD_CYCLES,
  parameter int unsigned MEM_CYCLES  = cpu_pkg::MEM_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [ADDR_BITS-1:0]   prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   start,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   running,
  output logic                   halted
);

  import cpu_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_e;

  state_e                 state_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_BITS-1:0]   pc_q;
  logic [2:0]             dwell_q;
  logic                   running_q;
  logic                   halted_q;

  logic [ADDR_BITS-1:0]   fetch_addr;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic [1:0]             rd_cls;

  function automatic logic [2:0] dwell_of(input logic [1:0] cls);
    return (cls == CLS_STD) ? 3'(STD_CYCLES) : 3'(MEM_CYCLES);
  endfunction

  // IDLE always looks at word 0; RUN looks one word ahead so the next fetch is ready.
  always_comb begin
    fetch_addr = '0;
    if (state_q == S_RUN) begin
      fetch_addr = pc_q + 1'b1;
    end
  end

  assign rd_cls = rd_data[INSTR_WIDTH-1 -: 2];

  instr_store #(
    .WIDTH (INSTR_WIDTH),
    .AW    (ADDR_BITS)
  ) u_store (
    .clk   (clk),
    .we    (prog_we && (state_q == S_IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (fetch_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      pc_q      <= '0;
      dwell_q   <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !prog_we) begin
            pc_q <= '0;
            if (rd_cls == CLS_HALT) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
              instr_q  <= '0;
            end else begin
              // Extra cycle covers the CU's RESET->DECODE edge on the first word only.
              state_q   <= S_RUN;
              running_q <= 1'b1;
              instr_q   <= rd_data;
              dwell_q   <= dwell_of(rd_cls) + 3'd1;
            end
          end
        end
        S_RUN: begin
          if (dwell_q > 3'd1) begin
            dwell_q <= dwell_q - 3'd1;
          end else begin
            pc_q <= fetch_addr;
            if (rd_cls == CLS_HALT) begin
              state_q   <= S_HALT;
              running_q <= 1'b0;
              halted_q  <= 1'b1;
              instr_q   <= '0;
              dwell_q   <= '0;
            end else begin
              instr_q <= rd_data;
              dwell_q <= dwell_of(rd_cls);
            end
          end
        end
        S_HALT: begin
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instr   = instr_q;
  assign pc      = pc_q;
  assign running = running_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: per-cycle trace compared against a program-walking reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [19:0] prog_data = '0;
  logic        start = 1'b0;
  logic [19:0] instr;
  logic [4:0]  pc;
  logic        running;
  logic        halted;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [19:0] model_mem [32];
  logic [26:0] got;
  logic [26:0] exp;

  always #5 clk = ~clk;

  instr_fetch #(
    .INSTR_WIDTH (20),
    .ADDR_BITS   (5),
    .STD_CYCLES  (3),
    .MEM_CYCLES  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .instr     (instr),
    .pc        (pc),
    .running   (running),
    .halted    (halted)
  );

  function automatic int unsigned dwell(input logic [19:0] w);
    return (w[19:18] == 2'b01) ? 3 : 4;
  endfunction

  // Expected {instr, pc, running, halted} k cycles after the start edge.
  function automatic logic [26:0] model_at(input int unsigned k);
    int unsigned addr = 0;
    int unsigned t    = 0;
    int unsigned len;
    logic [19:0] w;
    w = model_mem[0];
    if (w[19:18] == 2'b00) return {20'h0, 5'd0, 1'b0, 1'b1};
    len = dwell(w) + 1;
    for (int i = 0; i < 100000; i++) begin
      if (k < t + len) return {w, 5'(addr), 1'b1, 1'b0};
      t    = t + len;
      addr = (addr + 1) % 32;
      w    = model_mem[addr];
      if (w[19:18] == 2'b00) return {20'h0, 5'(addr), 1'b0, 1'b1};
      len = dwell(w);
    end
    return '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    step();
  endtask

  task automatic load_word(input int unsigned a, input logic [19:0] d);
    prog_we   = 1'b1;
    prog_addr = 5'(a);
    prog_data = d;
    model_mem[a] = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    step();
    #3 rst = 1'b1;
    #1;
    got = {instr, pc, running, halted};
    n_checks++;
    if (got !== 27'h0) begin
      n_fail++;
      $display("FAIL reset_async got=%h exp=%h", got, 27'h0);
    end
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      got = {instr, pc, running, halted};
      n_checks++;
      if (got !== 27'h0) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got=%h exp=%h", c, got, 27'h0);
      end
    end
  endtask

  task automatic test_std_ops();
    apply_reset();
    load_word(0, 20'h4_1001);
    load_word(1, 20'h4_2002);
    load_word(2, 20'h0_0000);
    start_run();
    for (int unsigned k = 0; k < 12; k++) begin
      got = {instr, pc, running, halted};
      exp = model_at(k);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL std_ops k=%0d got=%h exp=%h", k, got, exp);
      end
      step();
    end
    n_checks++;
    if (halted !== 1'b1 || pc !== 5'd2 || instr !== 20'h0) begin
      n_fail++;
      $display("FAIL std_ops_halt got halted=%b pc=%0d instr=%h exp 1 2 0", halted, pc, instr);
    end
  endtask

  task automatic test_mixed();
    apply_reset();
    prog_we   = 1'b1;
    prog_addr = 5'd3;
    prog_data = 20'h0_0000;
    model_mem[3] = 20'h0_0000;
    start = 1'b1;
    step();
    prog_we = 1'b0;
    start   = 1'b0;
    got = {instr, pc, running, halted};
    n_checks++;
    if (got !== 27'h0) begin
      n_fail++;
      $display("FAIL start_with_we got=%h exp=%h", got, 27'h0);
    end
    load_word(0, 20'h4_0001);
    load_word(1, 20'h9_0010);
    load_word(2, 20'hC_0020);
    start_run();
    for (int unsigned k = 0; k < 16; k++) begin
      got = {instr, pc, running, halted};
      exp = model_at(k);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL mixed k=%0d got=%h exp=%h", k, got, exp);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int unsigned a = 0; a < 32; a++) load_word(a, {2'b01, 18'($urandom)});
    start_run();
    for (int unsigned k = 0; k < 106; k++) begin
      got = {instr, pc, running, halted};
      exp = model_at(k);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL wrap k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 97 || k == 99) begin
        n_checks++;
        if (pc !== 5'd0 || instr !== model_mem[0]) begin
          n_fail++;
          $display("FAIL wrap_pc0 k=%0d got pc=%0d instr=%h exp pc=0 instr=%h", k, pc, instr, model_mem[0]);
        end
      end
      if (k == 100) begin
        n_checks++;
        if (pc !== 5'd1) begin
          n_fail++;
          $display("FAIL wrap_redwell k=%0d got pc=%0d exp pc=1", k, pc);
        end
      end
      step();
    end
  endtask

  task automatic test_ignored();
    apply_reset();
    load_word(0, 20'h4_1111);
    load_word(1, 20'h4_2222);
    load_word(2, 20'h8_0333);
    load_word(3, 20'h0_0000);
    start_run();
    for (int unsigned k = 0; k < 21; k++) begin
      got = {instr, pc, running, halted};
      exp = model_at(k);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL ignored k=%0d got=%h exp=%h", k, got, exp);
      end
      prog_we = 1'b0;
      start   = 1'b0;
      if (k == 1 || k == 13) begin
        prog_we   = 1'b1;
        prog_addr = 5'd1;
        prog_data = (k == 1) ? 20'h4_DEAD : 20'h4_BEEF;
      end
      if (k == 2 || k == 14) start = 1'b1;
      step();
    end
    prog_we = 1'b0;
    start   = 1'b0;
    apply_reset();
    start_run();
    for (int unsigned k = 0; k < 12; k++) begin
      got = {instr, pc, running, halted};
      exp = model_at(k);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL ignored_rerun k=%0d got=%h exp=%h", k, got, exp);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int unsigned a = 0; a < 5; a++) load_word(a, {2'b01, 18'(a * 18'h111 + 1)});
    load_word(5, 20'h0_0000);
    start_run();
    for (int unsigned k = 0; k <= 8; k++) begin
      got = {instr, pc, running, halted};
      exp = model_at(k);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL async_pre k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k < 8) step();
    end
    #3 rst = 1'b1;
    #1;
    got = {instr, pc, running, halted};
    n_checks++;
    if (got !== 27'h0) begin
      n_fail++;
      $display("FAIL async_mid_run got=%h exp=%h", got, 27'h0);
    end
    #1 rst = 1'b0;
    step();
    start_run();
    for (int unsigned k = 0; k < 22; k++) begin
      got = {instr, pc, running, halted};
      exp = model_at(k);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL async_replay k=%0d got=%h exp=%h", k, got, exp);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      for (int unsigned a = 0; a < 32; a++) begin
        logic [1:0] cls;
        cls = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        if (a == 0) cls = (it == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        load_word(a, {cls, 18'($urandom)});
      end
      start_run();
      for (int unsigned k = 0; k < 60; k++) begin
        got = {instr, pc, running, halted};
        exp = model_at(k);
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL random it=%0d k=%0d got=%h exp=%h", it, k, got, exp);
        end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_std_ops();
    test_mixed();
    test_wrap();
    test_ignored();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
